// File: rtl/hazard_controller_if.sv
// Hazard controller bus: decode/execute hazard inputs and pipeline stall/flush controls.
interface hazard_controller_if;
  logic [4:0] fd_rs1_address_i;
  logic [4:0] fd_rs2_address_i;
  logic       fd_rs1_used_i;
  logic       fd_rs2_used_i;
  logic       dx_valid_i;
  logic       dx_is_load_i;
  logic [4:0] dx_rd_address_i;
  logic       dx_multicycle_i;
  logic       mc_done_i;
  logic       redirect_i;
  logic       pc_stall_o;
  logic       fd_stall_o;
  logic       dx_stall_o;
  logic       fd_flush_o;
  logic       dx_flush_o;
  logic       xm_flush_o;
  logic       mc_start_o;
  logic       error_o;

  // Pipeline side: supplies hazard information, consumes controls
  modport master (
    output fd_rs1_address_i, fd_rs2_address_i, fd_rs1_used_i, fd_rs2_used_i,
    output dx_valid_i, dx_is_load_i, dx_rd_address_i, dx_multicycle_i,
    output mc_done_i, redirect_i,
    input  pc_stall_o, fd_stall_o, dx_stall_o, fd_flush_o, dx_flush_o,
    input  xm_flush_o, mc_start_o, error_o
  );

  // Controller side
  modport slave (
    input  fd_rs1_address_i, fd_rs2_address_i, fd_rs1_used_i, fd_rs2_used_i,
    input  dx_valid_i, dx_is_load_i, dx_rd_address_i, dx_multicycle_i,
    input  mc_done_i, redirect_i,
    output pc_stall_o, fd_stall_o, dx_stall_o, fd_flush_o, dx_flush_o,
    output xm_flush_o, mc_start_o, error_o
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use bubbles, multi-cycle EX hold, redirect flushes.
module hazard_controller #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MC_TIMEOUT   = 64
) (
  input logic              clk_i,
  input logic              rst_ni,
  hazard_controller_if.slave bus
);

  localparam int unsigned BUB_W = 2;
  localparam int unsigned TO_W  = (MC_TIMEOUT < 2) ? 1 : $clog2(MC_TIMEOUT + 1);
  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_BUBBLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(MC_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MC_WAIT    = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [BUB_W-1:0] r_bub_cnt;
  logic [BUB_W-1:0] w_bub_cnt_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_cnt_next;
  logic             r_error;
  logic             w_error_next;
  logic             w_rs1_match;
  logic             w_rs2_match;
  logic             w_hz;

  // Load-use detection; x0 is never a real producer
  assign w_rs1_match = bus.fd_rs1_used_i && (bus.fd_rs1_address_i == bus.dx_rd_address_i);
  assign w_rs2_match = bus.fd_rs2_used_i && (bus.fd_rs2_address_i == bus.dx_rd_address_i);
  assign w_hz = bus.dx_valid_i && bus.dx_is_load_i && (bus.dx_rd_address_i != 5'd0) &&
                (w_rs1_match || w_rs2_match);

  assign bus.error_o = r_error;

  // State, counters and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_RUN;
      r_bub_cnt <= '0;
      r_to_cnt  <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bub_cnt <= w_bub_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
      r_error   <= w_error_next;
    end
  end

  // Next state and combinational controls; everything held low while in reset
  always_comb begin
    w_state_next   = r_state;
    w_bub_cnt_next = r_bub_cnt;
    w_to_cnt_next  = r_to_cnt;
    w_error_next   = r_error;
    bus.pc_stall_o = 1'b0;
    bus.fd_stall_o = 1'b0;
    bus.dx_stall_o = 1'b0;
    bus.fd_flush_o = 1'b0;
    bus.dx_flush_o = 1'b0;
    bus.xm_flush_o = 1'b0;
    bus.mc_start_o = 1'b0;

    if (rst_ni) begin
      case (r_state)
        ST_RUN: begin
          if (bus.redirect_i) begin
            // redirect kills the dependent instruction, so it wins over hz
            bus.fd_flush_o = 1'b1;
            bus.dx_flush_o = 1'b1;
          end else if (bus.dx_valid_i && bus.dx_multicycle_i) begin
            bus.mc_start_o = 1'b1;
            bus.pc_stall_o = 1'b1;
            bus.fd_stall_o = 1'b1;
            bus.dx_stall_o = 1'b1;
            bus.xm_flush_o = 1'b1;
            w_to_cnt_next  = '0;
            w_state_next   = ST_MC_WAIT;
          end else if (w_hz) begin
            bus.pc_stall_o = 1'b1;
            bus.fd_stall_o = 1'b1;
            bus.dx_flush_o = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              w_bub_cnt_next = BUB_INIT;
              w_state_next   = ST_LOAD_STALL;
            end
          end
        end

        ST_LOAD_STALL: begin
          bus.pc_stall_o = 1'b1;
          bus.fd_stall_o = 1'b1;
          bus.dx_flush_o = 1'b1;
          if (r_bub_cnt <= BUB_W'(1)) begin
            w_bub_cnt_next = '0;
            w_state_next   = ST_RUN;
          end else begin
            w_bub_cnt_next = r_bub_cnt - BUB_W'(1);
          end
        end

        ST_MC_WAIT: begin
          if (bus.mc_done_i) begin
            // result advances to XM; a new op may start only next cycle
            w_state_next = ST_RUN;
          end else begin
            bus.pc_stall_o = 1'b1;
            bus.fd_stall_o = 1'b1;
            bus.dx_stall_o = 1'b1;
            bus.xm_flush_o = 1'b1;
            if (r_to_cnt != TO_MAX) begin
              w_to_cnt_next = r_to_cnt + TO_W'(1);
            end
            if ((MC_TIMEOUT != 0) && (w_to_cnt_next == TO_MAX)) begin
              w_error_next = 1'b1;
            end
          end
        end

        default: begin
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized bench for hazard_controller: two parameterizations against a behavioural model.
module tb_hazard_controller;

  localparam int N = 2;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       dv;
    logic       ld;
    logic [4:0] rd;
    logic       mc;
    logic       done;
    logic       redir;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if ifa ();
  hazard_controller_if ifb ();

  hazard_controller #(.LOAD_BUBBLES(1), .MC_TIMEOUT(4)) u_dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifa)
  );

  hazard_controller #(.LOAD_BUBBLES(3), .MC_TIMEOUT(64)) u_dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifb)
  );

  int lb_p [N] = '{1, 3};
  int to_p [N] = '{4, 64};

  int checks   = 0;
  int failures = 0;
  stim_t s;

  // Model: what the pipeline is currently doing, in plain terms
  localparam int M_RUN = 0, M_BUBBLING = 1, M_WAITING = 2;
  int m_mode   [N];
  int m_left   [N];
  int m_waited [N];
  bit m_err    [N];
  int n_mode   [N];
  int n_left   [N];
  int n_waited [N];
  bit n_err    [N];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (pc,fd,dx stall; fd,dx,xm flush; start; err) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_out(input int k);
    if (k == 0)
      return {ifa.pc_stall_o, ifa.fd_stall_o, ifa.dx_stall_o, ifa.fd_flush_o,
              ifa.dx_flush_o, ifa.xm_flush_o, ifa.mc_start_o, ifa.error_o};
    return {ifb.pc_stall_o, ifb.fd_stall_o, ifb.dx_stall_o, ifb.fd_flush_o,
            ifb.dx_flush_o, ifb.xm_flush_o, ifb.mc_start_o, ifb.error_o};
  endfunction

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    return t;
  endfunction

  task automatic apply();
    ifa.fd_rs1_address_i = s.rs1;  ifb.fd_rs1_address_i = s.rs1;
    ifa.fd_rs2_address_i = s.rs2;  ifb.fd_rs2_address_i = s.rs2;
    ifa.fd_rs1_used_i    = s.u1;   ifb.fd_rs1_used_i    = s.u1;
    ifa.fd_rs2_used_i    = s.u2;   ifb.fd_rs2_used_i    = s.u2;
    ifa.dx_valid_i       = s.dv;   ifb.dx_valid_i       = s.dv;
    ifa.dx_is_load_i     = s.ld;   ifb.dx_is_load_i     = s.ld;
    ifa.dx_rd_address_i  = s.rd;   ifb.dx_rd_address_i  = s.rd;
    ifa.dx_multicycle_i  = s.mc;   ifb.dx_multicycle_i  = s.mc;
    ifa.mc_done_i        = s.done; ifb.mc_done_i        = s.done;
    ifa.redirect_i       = s.redir; ifb.redirect_i      = s.redir;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_mode[k] = M_RUN; m_left[k] = 0; m_waited[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  // Expected controls for this cycle, plus where the pipeline will be next cycle
  task automatic model_eval(input int k, output logic [7:0] e);
    bit hz;
    bit stall_front, stall_dx, fdf, dxf, xmf, start;
    hz = s.dv && s.ld && (s.rd != 0) &&
         ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    stall_front = 0; stall_dx = 0; fdf = 0; dxf = 0; xmf = 0; start = 0;
    n_mode[k] = m_mode[k]; n_left[k] = m_left[k];
    n_waited[k] = m_waited[k]; n_err[k] = m_err[k];
    if (m_mode[k] == M_RUN) begin
      if (s.redir) begin
        fdf = 1; dxf = 1;
      end else if (s.dv && s.mc) begin
        start = 1; stall_front = 1; stall_dx = 1; xmf = 1;
        n_mode[k] = M_WAITING; n_waited[k] = 0;
      end else if (hz) begin
        stall_front = 1; dxf = 1;
        if (lb_p[k] > 1) begin
          n_mode[k] = M_BUBBLING; n_left[k] = lb_p[k] - 1;
        end
      end
    end else if (m_mode[k] == M_BUBBLING) begin
      stall_front = 1; dxf = 1;
      n_left[k] = m_left[k] - 1;
      if (n_left[k] == 0) n_mode[k] = M_RUN;
    end else begin
      if (s.done) begin
        n_mode[k] = M_RUN;
      end else begin
        stall_front = 1; stall_dx = 1; xmf = 1;
        n_waited[k] = m_waited[k] + 1;
        if (to_p[k] != 0 && n_waited[k] >= to_p[k]) n_err[k] = 1'b1;
      end
    end
    e = {stall_front, stall_front, stall_dx, fdf, dxf, xmf, start, m_err[k]};
  endtask

  // One clock: drive, check mid-cycle, advance DUT and model together
  task automatic run_cycle(input string tag);
    logic [7:0] e;
    apply();
    #2;
    for (int k = 0; k < N; k++) begin
      model_eval(k, e);
      chk($sformatf("%s_%0d", tag, k), dut_out(k), e);
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      m_mode[k] = n_mode[k]; m_left[k] = n_left[k];
      m_waited[k] = n_waited[k]; m_err[k] = n_err[k];
    end
    #1;
  endtask

  // Asynchronous reset pulse landing in the middle of a cycle
  task automatic pulse_reset();
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) chk($sformatf("rst_async_%0d", k), dut_out(k), 8'h00);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("rst_hold_%0d", k), dut_out(k), 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic load_use(input logic [4:0] r);
    s = idle(); s.dv = 1; s.ld = 1; s.rd = r; s.rs1 = r; s.u1 = 1; s.rs2 = 5'd7;
  endtask

  initial begin
    s = idle();
    model_reset();
    apply();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("rst_state_%0d", k), dut_out(k), 8'h00);
    rst_n = 1'b1;

    // load-use on x5, then bubbles drain
    load_use(5'd5);  run_cycle("lu_x5");
    s = idle();      repeat (3) run_cycle("lu_drain");
    load_use(5'd0);  run_cycle("lu_x0");
    load_use(5'd5);  s.redir = 1; run_cycle("lu_redir");
    s = idle();      run_cycle("idle");

    // multi-cycle, done 5 cycles after start, then back-to-back
    s = idle(); s.dv = 1; s.mc = 1; run_cycle("mc_start");
    repeat (4) run_cycle("mc_wait");
    s.done = 1; run_cycle("mc_done");
    s.done = 0; run_cycle("mc_b2b_start");
    repeat (2) run_cycle("mc_wait2");
    s.done = 1; run_cycle("mc_done2");
    s = idle(); run_cycle("idle");

    // timeout then late done
    pulse_reset();
    s = idle(); s.dv = 1; s.mc = 1; run_cycle("to_start");
    repeat (7) run_cycle("to_wait");
    s.done = 1; run_cycle("to_late_done");
    s = idle(); repeat (2) run_cycle("to_after");

    // reset mid-wait, then a fresh start
    s = idle(); s.dv = 1; s.mc = 1; run_cycle("rw_start");
    repeat (2) run_cycle("rw_wait");
    pulse_reset();
    run_cycle("rw_fresh_start");
    s.done = 1; run_cycle("rw_done");

    // randomized traffic with small register space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        pulse_reset();
      end else begin
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.rd    = 5'($urandom_range(0, 3));
        s.u1    = ($urandom_range(0, 3) != 0);
        s.u2    = ($urandom_range(0, 1) != 0);
        s.dv    = ($urandom_range(0, 3) != 0);
        s.ld    = ($urandom_range(0, 1) != 0);
        s.mc    = ($urandom_range(0, 5) == 0);
        s.done  = ($urandom_range(0, 4) == 0);
        s.redir = ($urandom_range(0, 7) == 0);
        run_cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the 5-stage core (FD, DX, XM, MW).
- Sits alongside the forwarding unit and covers the hazards forwarding cannot resolve:
  - load-use dependencies, by inserting bubbles;
  - multi-cycle execute operations, by holding EX until the unit completes;
  - control redirects from EX, by flushing the younger stages.
- Drives the stall/flush controls of the PC and pipeline registers, plus the start strobe of the multi-cycle unit.

Parameters:
- LOAD_BUBBLES, 1: bubbles inserted on a load-use hazard (1..3); covers load-to-WB-forward latency.
- MC_TIMEOUT, 64: max cycles spent in MC_WAIT before error_o is raised; 0 disables the timeout.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- fd_rs1_address_i  input  register_e(5)  rs1 of the instruction in decode.
- fd_rs2_address_i  input  register_e(5)  rs2 of the instruction in decode.
- fd_rs1_used_i  input  1  decode instruction reads rs1.
- fd_rs2_used_i  input  1  decode instruction reads rs2.
- dx_valid_i  input  1  DX holds a real (non-bubble) instruction.
- dx_is_load_i  input  1  DX instruction is a load.
- dx_rd_address_i  input  register_e(5)  rd of the DX instruction.
- dx_multicycle_i  input  1  DX instruction needs the multi-cycle unit.
- mc_done_i  input  1  multi-cycle unit result valid; single-cycle pulse.
- redirect_i  input  1  EX resolved a taken branch/jump or mispredict.
- pc_stall_o  output  1  hold the PC.
- fd_stall_o  output  1  hold the FD register.
- dx_stall_o  output  1  hold the DX register.
- fd_flush_o  output  1  load a bubble into FD.
- dx_flush_o  output  1  load a bubble into DX.
- xm_flush_o  output  1  load a bubble into XM.
- mc_start_o  output  1  start the multi-cycle unit; one-cycle pulse.
- error_o  output  1  sticky multi-cycle timeout flag.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state = RUN, bubble counter = 0, timeout counter = 0, error_o = 0.
  - All outputs are low during and after reset until a hazard occurs.
- Load-use hazard (hz):
  - hz = dx_valid_i & dx_is_load_i & dx_rd_address_i != 0 & ((fd_rs1_used_i & fd_rs1_address_i == dx_rd_address_i) | (fd_rs2_used_i & fd_rs2_address_i == dx_rd_address_i)).
  - Address x0 never creates a hazard.
- State RUN, evaluated in priority order:
  1. redirect_i: fd_flush_o = dx_flush_o = 1, no stalls. This overrides hz, because the dependent instruction is killed. Stay in RUN.
  2. dx_valid_i & dx_multicycle_i: mc_start_o = 1, pc/fd/dx stall = 1, xm_flush_o = 1. Next state is MC_WAIT with timeout counter = 0.
  3. hz: pc_stall_o = fd_stall_o = 1, dx_flush_o = 1.
     - If LOAD_BUBBLES > 1, go to LOAD_STALL with bubble counter = LOAD_BUBBLES-1.
     - Otherwise stay in RUN; the bubble now in DX clears hz.
- State LOAD_STALL:
  - pc_stall_o = fd_stall_o = dx_flush_o = 1.
  - Bubble counter decrements each cycle; when it reaches 0, go to RUN.
  - redirect_i cannot occur here (DX holds a bubble) and is ignored.
- State MC_WAIT:
  - While mc_done_i = 0: pc/fd/dx stall = 1, xm_flush_o = 1, and the timeout counter increments, saturating.
  - Cycle with mc_done_i = 1: all stalls and flushes are 0, so the instruction advances to XM. Go to RUN.
  - mc_start_o is never re-asserted in MC_WAIT.
  - On the return to RUN, a new multi-cycle instruction in DX starts in the following cycle, not the done cycle.
  - Timeout: if MC_TIMEOUT != 0 and the counter reaches MC_TIMEOUT, set error_o.
    - error_o stays set until reset.
    - The FSM stays in MC_WAIT.
  - mc_done_i outside MC_WAIT is ignored.
- Outputs are combinational from state and inputs; state, counters and error_o are registered.
- Latency:
  - A load-use hazard costs exactly LOAD_BUBBLES cycles.
  - A multi-cycle op costs N+1 cycles in EX, where mc_done_i arrives N cycles after mc_start_o.
- Reset asserted mid-operation, in any state, returns to RUN immediately with all outputs low.

Test Plan:
- Load-use, LOAD_BUBBLES=1: DX lw rd=x5, FD add rs1=x5 → one cycle with pc_stall_o=fd_stall_o=dx_flush_o=1, then all low. Repeat with rd=x0 → no stall.
- Load-use with redirect_i=1 in the same cycle → fd_flush_o=dx_flush_o=1, pc_stall_o=0, state stays RUN.
- LOAD_BUBBLES=3: load-use → exactly 3 consecutive cycles of stall+dx_flush_o, back in RUN on the 4th cycle.
- Multi-cycle: dx_multicycle_i=1, mc_done_i 5 cycles after start → mc_start_o pulses once, stalls and xm_flush_o high for 5 cycles, all low in the done cycle. Back-to-back multi-cycle ops → second mc_start_o one cycle after done.
- MC_TIMEOUT=4, mc_done_i never asserted → error_o rises after 4 wait cycles and stays high; a late mc_done_i releases the stall, error_o stays 1.
- rst_ni pulsed low mid-MC_WAIT → outputs low asynchronously, error_o=0, next dx_multicycle_i produces a fresh mc_start_o.
